imem_dmem_arbiter: RTL
======================

Name: imem_dmem_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between the fetch stage (I-side) and the memory stage (D-side).
- Arbitrates each cycle the port is free; D-side has priority, with an anti-starvation override for I-side.
- Sequences fixed-latency memory transactions and returns read data with a one-cycle valid pulse.
- Generates stall_f / stall_m for the pipeline; honours branch flushes by discarding in-flight fetch data.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles from mem_req to mem_rdata valid (>=1).
- STARVE_MAX, 4, consecutive D grants while I waits before I is forced to win (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- i_req  in  1  fetch request; held until i_valid or i_flush.
- i_addr  in  ADDR_W  fetch address; stable while i_req.
- i_flush  in  1  taken branch (PCSrcE); kills the pending/in-flight fetch.
- i_rdata  out  DATA_W  instruction; meaningful only when i_valid.
- i_valid  out  1  one-cycle fetch completion pulse.
- d_req  in  1  load/store request; held until d_valid.
- d_we  in  1  1=store, 0=load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data; meaningful only when d_valid.
- d_valid  out  1  one-cycle data completion pulse.
- mem_req  out  1  memory access strobe, one cycle per transaction.
- mem_we  out  1  memory write enable, qualified by mem_req.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  valid MEM_LAT cycles after mem_req.
- stall_f  out  1  stall fetch/decode.
- stall_m  out  1  stall memory stage and older.
- perf_i_stall  out  32  I-stall cycle count (see Optional Feature).
- perf_d_stall  out  32  D-stall cycle count (see Optional Feature).

Behaviour:
- State machine: IDLE, BUSY_I, BUSY_D.
  - 2-bit owner state.
  - Latency counter, width clog2(MEM_LAT+1).
  - Starvation counter, width clog2(STARVE_MAX+1).
  - Kill flag.
- Reset (rst=0, asynchronous):
  - State=IDLE; counters=0; kill=0.
  - All outputs 0, including mem_req, i_valid, d_valid and both perf counters.
- IDLE arbitration (combinational, same cycle):
  - d_req && !(i_req && starve==STARVE_MAX): grant D.
  - Else i_req && !i_flush: grant I.
  - Else stay in IDLE.
- On grant:
  - mem_req=1 for that cycle; mem_addr, mem_we, mem_wdata taken from the winner (mem_we=0 for I).
  - Latency counter loaded with MEM_LAT; go to BUSY_x.
- Starvation counter:
  - D grant while i_req=1: increments, saturating at STARVE_MAX.
  - Any I grant, or i_req=0: clears to 0.
- BUSY_x:
  - Counter decrements each cycle.
  - At count==1: the x_valid pulse fires, x_rdata = mem_rdata (passed through, unregistered), and state returns to IDLE.
  - Completion therefore occurs exactly MEM_LAT cycles after mem_req; next grant can occur the following cycle.
  - Throughput: one transaction per MEM_LAT+1 cycles.
- Stores: d_valid pulses at the same point; d_rdata undefined (drive 0).
- Outside a pulse, rdata outputs hold 0.
- Stalls (combinational):
  - stall_f = i_req && !i_valid && !i_flush.
  - stall_m = d_req && !d_valid.
- Flush:
  - i_flush in BUSY_I sets kill. At completion, i_valid is suppressed, kill clears and the memory access finishes silently.
  - i_flush in IDLE blocks an I grant that cycle.
  - i_flush during BUSY_D has no effect.
- Simultaneous requests in IDLE: D wins unless starve==STARVE_MAX.
- Dropped request: i_req or d_req deasserting mid-BUSY (protocol violation apart from flush) does not abort the access; valid still pulses.
- mem_req is never asserted while BUSY; at most one transaction is outstanding.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- When defined: perf_i_stall increments each cycle stall_f=1, and perf_d_stall each cycle stall_m=1. Both are 32-bit, wrap 0xFFFFFFFF->0, and reset to 0.
- When undefined: no counter flops; both outputs tied to 0; port list unchanged.

Test Plan:
- Single fetch: reset, i_req=1, i_addr=0x10, mem_rdata=0x00500093 at T+2 -> mem_req at T; i_valid at T+2 with i_rdata=0x00500093; stall_f=1 at T,T+1 and 0 at T+2.
- Simultaneous i_req and d_req (load 0x100) in IDLE -> D granted first (mem_addr=0x100, mem_we=0); d_valid at T+2; I granted at T+3; i_valid at T+5.
- Starvation: d_req held continuously with i_req=1 -> after 4 D grants, 5th grant goes to I; starve counter back to 0.
- Flush: i_flush pulsed at T+1 of an I transaction -> no i_valid at T+2; stall_f=0 during flush; new fetch granted at T+3.
- Store: d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF at grant; d_valid at T+2; d_rdata=0.
- Reset mid-transaction: rst=0 asserted in BUSY_D -> all outputs 0 immediately; after release, the held d_req is re-granted as new. With ARB_PERF_CNT_EN defined: perf counters match stall-cycle counts across the preceding scenarios, then reset to 0.

Source files
------------

// File: rtl/imem_dmem_arbiter.sv
// Arbiter sharing one single-ported unified memory between fetch (I) and memory stage (D).
// Optional stall performance counters are built when ARB_PERF_CNT_EN is defined.
//
// state  | meaning
// IDLE   | port free; D has priority unless I has waited STARVE_MAX D grants
// BUSY_I | fetch in flight; a flush marks it killed so its data is dropped
// BUSY_D | load/store in flight; completes with d_valid regardless of flush
module imem_dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_flush,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_f,
  output logic              stall_m,
  output logic [31:0]       perf_i_stall,
  output logic [31:0]       perf_d_stall
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arbState_t;

  arbState_t        state, stateNext;
  logic [CNT_W-1:0] latCnt, latCntNext;
  logic [STV_W-1:0] starveCnt, starveCntNext;
  logic             killFlag, killNext;
  logic             storeFlag, storeNext;
  logic             grantI, grantD;
  logic             lastCycle;
  logic             starveHit;

  assign lastCycle = (latCnt == CNT_W'(1));
  assign starveHit = (starveCnt == STV_W'(STARVE_MAX));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      latCnt    <= '0;
      starveCnt <= '0;
      killFlag  <= 1'b0;
      storeFlag <= 1'b0;
    end else begin
      state     <= stateNext;
      latCnt    <= latCntNext;
      starveCnt <= starveCntNext;
      killFlag  <= killNext;
      storeFlag <= storeNext;
    end
  end

  always_comb begin
    stateNext  = state;
    latCntNext = latCnt;
    killNext   = killFlag;
    storeNext  = storeFlag;
    grantI     = 1'b0;
    grantD     = 1'b0;
    case (state)
      IDLE: begin
        // Grants are gated by rst so mem_req stays low while reset is held
        if (rst && d_req && !(i_req && starveHit)) begin
          grantD     = 1'b1;
          stateNext  = BUSY_D;
          latCntNext = CNT_W'(MEM_LAT);
          storeNext  = d_we;
        end else if (rst && i_req && !i_flush) begin
          grantI     = 1'b1;
          stateNext  = BUSY_I;
          latCntNext = CNT_W'(MEM_LAT);
          killNext   = 1'b0;
        end
      end
      BUSY_I: begin
        latCntNext = latCnt - CNT_W'(1);
        if (lastCycle) begin
          stateNext = IDLE;
          killNext  = 1'b0;
        end else if (i_flush) begin
          killNext = 1'b1;
        end
      end
      BUSY_D: begin
        latCntNext = latCnt - CNT_W'(1);
        if (lastCycle) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_comb begin
    starveCntNext = starveCnt;
    if (grantD && i_req) begin
      if (!starveHit) begin
        starveCntNext = starveCnt + STV_W'(1);
      end
    end else if (grantI || !i_req) begin
      starveCntNext = '0;
    end
  end

  // A flush arriving on the completion cycle also drops the fetch data
  assign i_valid = (state == BUSY_I) && lastCycle && !killFlag && !i_flush;
  assign d_valid = (state == BUSY_D) && lastCycle;

  assign i_rdata = i_valid ? mem_rdata : '0;
  assign d_rdata = (d_valid && !storeFlag) ? mem_rdata : '0;

  assign mem_req   = grantI || grantD;
  assign mem_we    = grantD && d_we;
  assign mem_addr  = grantD ? d_addr : (grantI ? i_addr : '0);
  assign mem_wdata = (grantD && d_we) ? d_wdata : '0;

  assign stall_f = rst && i_req && !i_valid && !i_flush;
  assign stall_m = rst && d_req && !d_valid;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perfI, perfD;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perfI <= '0;
      perfD <= '0;
    end else begin
      if (stall_f) perfI <= perfI + 32'd1;
      if (stall_m) perfD <= perfD + 32'd1;
    end
  end

  assign perf_i_stall = perfI;
  assign perf_d_stall = perfD;
`else
  assign perf_i_stall = '0;
  assign perf_d_stall = '0;
`endif

endmodule
